// File: rtl/rf_write_arbiter.sv
// Register-file write-port sequencer and arbiter.
// After reset, zeros are swept through every register address (INIT). Then the
// single write port is shared round-robin between NREQ writeback requesters (RUN).
// Writes to address 0 in RUN are consumed but suppressed, so x0 stays zero.
module rf_write_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic [1:0]         wr_src,
  output logic               init_busy
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [AW-1:0] LastReg = AW'(NREGS - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [1:0]    wr_src_q, wr_src_d;

  logic          found;
  logic [1:0]    gidx;
  logic [1:0]    idx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // (base + off) mod NREQ; both operands are already below NREQ
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'(NREQ)) s = s - 3'(NREQ);
    return s[1:0];
  endfunction

  // Round-robin grant: first valid requester scanning from ptr; nothing during INIT
  always_comb begin
    found     = 1'b0;
    gidx      = '0;
    idx       = '0;
    req_ready = '0;
    if (state_q == StRun) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = rr_idx(ptr_q, 2'(k));
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
      if (found) req_ready[gidx] = 1'b1;
    end
  end

  // Payload of the granted requester
  always_comb begin
    sel_addr = req_addr[32'(gidx) * AW +: AW];
    sel_data = req_data[32'(gidx) * DW +: DW];
  end

  // Next-state: sweep issue in INIT, granted transfer (or idle) in RUN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    if (state_q == StInit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q;
      wr_data_d = '0;
      wr_src_d  = '0;
      cnt_d     = cnt_q + AW'(1);
      if (cnt_q == LastReg) state_d = StRun;
    end else if (found) begin
      // Address 0 is accepted but never written in RUN
      wr_en_d   = (sel_addr != '0);
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      wr_src_d  = gidx;
      ptr_d     = rr_idx(gidx, 2'd1);
    end
  end

  // State and registered write-port outputs; reset restarts the sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_src    = wr_src_q;
  assign init_busy = (state_q == StInit);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: expected writes are queued as stimulus is
// driven and checked against wr_* by a monitor after each rising edge.
module tb_rf_write_arbiter;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [4:0]  a [3];
  logic [31:0] d [3];
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_src;
  logic        init_busy;

  logic [31:0] rf [32];
  exp_t        exp_q [$];
  exp_t        mon_e;
  exp_t        e;
  int          total = 0;
  int          bad = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  rf_write_arbiter #(
    .NREQ (3),
    .AW   (5),
    .DW   (32),
    .NREGS(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_src   (wr_src),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Register file model: samples the write port on the falling edge
  always @(negedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  // Scoreboard monitor: one queued expectation per rising edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if (wr_en !== mon_e.en || (mon_e.en && (wr_addr !== mon_e.addr ||
          wr_data !== mon_e.data || wr_src !== mon_e.src))) begin
        bad++;
        $display("FAIL sb_write: got en=%0b addr=%0d data=%h src=%0d, want en=%0b addr=%0d data=%h src=%0d",
                 wr_en, wr_addr, wr_data, wr_src, mon_e.en, mon_e.addr, mon_e.data, mon_e.src);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic en, input logic [4:0] ad, input logic [31:0] da,
                      input logic [1:0] sr);
    e.en = en; e.addr = ad; e.data = da; e.src = sr;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    #2;
    req_valid = 3'b111;
    #1;
    total++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 || wr_src !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs: got en=%0b addr=%0d data=%h src=%0d, want 0/0/0/0",
               wr_en, wr_addr, wr_data, wr_src);
    end
    total++;
    if (init_busy !== 1'b1 || req_ready !== 3'b000) begin
      bad++;
      $display("FAIL reset_status: got busy=%0b ready=%b, want busy=1 ready=000",
               init_busy, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // requests held valid during the sweep must never see ready until RUN
  task automatic test_init_sweep;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'd0 || wr_src !== 2'd0) begin
        bad++;
        $display("FAIL sweep[%0d]: got en=%0b addr=%0d data=%h src=%0d, want 1/%0d/0/0",
                 i, wr_en, wr_addr, wr_data, wr_src, i);
      end
      total++;
      if (init_busy !== (i < 31)) begin
        bad++;
        $display("FAIL sweep_busy[%0d]: got %0b want %0b", i, init_busy, (i < 31));
      end
      total++;
      if (req_ready !== ((i < 31) ? 3'b000 : 3'b001)) begin
        bad++;
        $display("FAIL sweep_ready[%0d]: got %b want %b", i, req_ready,
                 ((i < 31) ? 3'b000 : 3'b001));
      end
    end
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    total++;
    if (wr_en !== 1'b0) begin
      bad++;
      $display("FAIL post_sweep_idle: got wr_en=%0b want 0", wr_en);
    end
    #1;
  endtask

  task automatic test_single_write;
    a[1] = 5'd5; d[1] = 32'hDEADBEEF;
    req_valid = 3'b010;
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++;
      $display("FAIL single_ready: got %b want 010", req_ready);
    end
    push(1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
    tick();
    req_valid = 3'b000;
    #1;
    total++;
    if (req_ready !== 3'b000) begin
      bad++;
      $display("FAIL single_idle_ready: got %b want 000", req_ready);
    end
    push(1'b0, 5'd0, 32'd0, 2'd0);
    @(negedge clk);
    #1;
    total++;
    if (rf[5] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_rf5: got %h want deadbeef", rf[5]);
    end
    tick();
  endtask

  task automatic test_x0_suppress;
    a[2] = 5'd0; d[2] = 32'hFFFFFFFF;
    req_valid = 3'b100;
    #1;
    total++;
    if (req_ready !== 3'b100) begin
      bad++;
      $display("FAIL x0_ready: got %b want 100", req_ready);
    end
    push(1'b0, 5'd0, 32'd0, 2'd0);
    tick();
    req_valid = 3'b000;
    @(negedge clk);
    #1;
    total++;
    if (rf[0] !== 32'd0) begin
      bad++;
      $display("FAIL x0_rf0: got %h want 00000000", rf[0]);
    end
    tick();
  endtask

  task automatic test_round_robin;
    int g;
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2;
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      g = c % 3;
      #1;
      total++;
      if (req_ready !== 3'(1 << g)) begin
        bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, 3'(1 << g));
      end
      push(1'b1, 5'(g + 1), 32'hA0 + 32'(g), 2'(g));
      tick();
    end
    req_valid = 3'b000;
    push(1'b0, 5'd0, 32'd0, 2'd0);
    tick();
  endtask

  task automatic test_collision;
    a[0] = 5'd7; d[0] = 32'h11;
    a[1] = 5'd7; d[1] = 32'h22;
    req_valid = 3'b011;
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL coll_first: got %b want 001", req_ready);
    end
    push(1'b1, 5'd7, 32'h11, 2'd0);
    tick();
    req_valid = 3'b010;
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++;
      $display("FAIL coll_second: got %b want 010", req_ready);
    end
    push(1'b1, 5'd7, 32'h22, 2'd1);
    tick();
    req_valid = 3'b000;
    push(1'b0, 5'd0, 32'd0, 2'd0);
    @(negedge clk);
    #1;
    total++;
    if (rf[7] !== 32'h22) begin
      bad++;
      $display("FAIL coll_rf7: got %h want 00000022", rf[7]);
    end
    tick();
  endtask

  // lone requester holding valid is granted on every cycle
  task automatic test_back_to_back;
    req_valid = 3'b001;
    for (int c = 0; c < 4; c++) begin
      a[0] = 5'(10 + c); d[0] = 32'h5000 + 32'(c);
      #1;
      total++;
      if (req_ready !== 3'b001) begin
        bad++;
        $display("FAIL b2b_grant[%0d]: got %b want 001", c, req_ready);
      end
      push(1'b1, 5'(10 + c), 32'h5000 + 32'(c), 2'd0);
      tick();
    end
    req_valid = 3'b000;
    push(1'b0, 5'd0, 32'd0, 2'd0);
    tick();
  endtask

  task automatic test_reset_mid_sweep;
    reset = 1'b1;
    req_valid = 3'b111;
    #1;
    total++;
    if (wr_en !== 1'b0 || init_busy !== 1'b1 || req_ready !== 3'b000) begin
      bad++;
      $display("FAIL rst_enter: got en=%0b busy=%0b ready=%b, want 0/1/000",
               wr_en, init_busy, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i)) begin
        bad++;
        $display("FAIL resweep[%0d]: got en=%0b addr=%0d want 1/%0d", i, wr_en, wr_addr, i);
      end
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0) begin
      bad++;
      $display("FAIL mid_sweep_drop: got en=%0b addr=%0d want 0/0", wr_en, wr_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd0) begin
      bad++;
      $display("FAIL sweep_restart: got en=%0b addr=%0d want 1/0", wr_en, wr_addr);
    end
    repeat (31) @(posedge clk);
    #1;
    total++;
    if (wr_addr !== 5'd31 || init_busy !== 1'b0 || req_ready !== 3'b001) begin
      bad++;
      $display("FAIL sweep_end: got addr=%0d busy=%0b ready=%b want 31/0/001",
               wr_addr, init_busy, req_ready);
    end
    req_valid = 3'b000;
    #1;
  endtask

  task automatic test_reset_mid_run;
    a[0] = 5'd20; a[1] = 5'd21; a[2] = 5'd22;
    d[0] = 32'hC0; d[1] = 32'hC1; d[2] = 32'hC2;
    req_valid = 3'b111;
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL run_grant0: got %b want 001", req_ready);
    end
    push(1'b1, 5'd20, 32'hC0, 2'd0);
    tick();
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++;
      $display("FAIL run_grant1: got %b want 010", req_ready);
    end
    push(1'b1, 5'd21, 32'hC1, 2'd1);
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (wr_en !== 1'b0 || req_ready !== 3'b000 || init_busy !== 1'b1 || wr_addr !== 5'd0) begin
      bad++;
      $display("FAIL run_reset: got en=%0b ready=%b busy=%0b addr=%0d want 0/000/1/0",
               wr_en, req_ready, init_busy, wr_addr);
    end
    req_valid = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd0 || wr_data !== 32'd0 || init_busy !== 1'b1) begin
      bad++;
      $display("FAIL run_reinit: got en=%0b addr=%0d data=%h busy=%0b want 1/0/0/1",
               wr_en, wr_addr, wr_data, init_busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    test_reset();
    test_init_sweep();
    test_single_write();
    test_x0_suppress();
    test_round_robin();
    test_collision();
    test_back_to_back();
    test_reset_mid_sweep();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Sequencer and arbiter for the single register-file write port. After reset it sweeps zeros through every register address. It then shares the port between NREQ writeback requesters (for example ALU, load unit and debug) with round-robin fairness. It sits between the writeback sources and the register file's write port (write enable, write address, write data), which samples on the falling clock edge.

## Interface
- NREQ, 3, number of write requesters (2..4)
- AW, 5, register address width
- DW, 32, data width
- NREGS, 32, registers cleared by the init sweep (≤ 2^AW)

- clk  in  1  system clock; all state on rising edge
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  destination; requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  data; requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant, combinational; transfer = valid & ready
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  AW  register-file write address (registered)
- wr_data  out  DW  register-file write data (registered)
- wr_src  out  2  index of the requester that produced the current wr_* (registered)
- init_busy  out  1  high while the init sweep is issuing

## Operation
- States: INIT, RUN. Reset forces INIT.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, wr_src=0.
  - init_busy=1, req_ready=0.
  - Sweep counter cnt=0, round-robin pointer ptr=0.
- INIT behaviour:
  - Each rising edge: wr_en<=1, wr_addr<=cnt, wr_data<=0, wr_src<=0, cnt<=cnt+1.
  - When cnt==NREGS-1 is issued, the state becomes RUN.
  - req_ready is all zeros throughout INIT.
  - init_busy = (state==INIT).
- RUN arbitration:
  - Grant goes to the first i with req_valid[i]=1, scanning ptr, ptr+1, … mod NREQ.
  - req_ready[i]=1 for that i only. req_ready is all zeros if no request is valid.
- RUN transfer on a rising edge:
  - wr_addr<=req_addr[g], wr_data<=req_data[g], wr_src<=g.
  - wr_en<=1, unless req_addr[g]==0, in which case wr_en<=0.
  - ptr<=(g+1) mod NREQ.
- Address 0:
  - In RUN, writes to address 0 are consumed (ready given) but suppressed, so x0 stays 0.
  - The INIT sweep does write address 0.
- No transfer in RUN: wr_en<=0, wr_addr/wr_data/wr_src hold, ptr holds.
- Same-address requests in one cycle are serialized in grant order, so the last granted value persists.
- At most one write per cycle; never more than one req_ready bit high.
- Requesters must hold valid/addr/data stable until ready; the arbiter need not check this.

## Timing
- Outputs change only on rising edges, so they are stable when the register file samples on the falling edge of the same cycle.
- Init sweep, with reset deasserted before rising edge 1:
  - Rising edges 1..NREGS present addresses 0..NREGS-1.
  - init_busy falls after edge NREGS.
  - req_ready may assert in the cycle following edge NREGS, the same cycle in which the address NREGS-1 write is presented.
- Request latency:
  - A transfer at rising edge k appears on wr_* in cycle k..k+1.
  - The register file writes it at the falling edge inside that cycle.
  - A read of that address is valid from that falling edge.
- Throughput: one accepted write per cycle. A lone requester holding valid is granted every cycle.
- Fairness: with all NREQ valid continuously, each requester is granted exactly once per NREQ cycles.
- Reset mid-operation, asynchronously:
  - wr_en drops immediately, req_ready goes to zero, in-flight writes are lost.
  - After release the sweep restarts from address 0.

## Test plan
- Init sweep:
  - Release reset → wr_en=1 for 32 consecutive cycles with wr_addr 0..31 and wr_data=0.
  - init_busy high for exactly those issuing cycles.
  - req_ready=0 throughout.
- Single write:
  - After init, requester 1 sends addr 5, data 0xDEADBEEF for one cycle.
  - req_ready=3'b010 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_src=1.
  - Register 5 reads 0xDEADBEEF after the falling edge.
- Round-robin:
  - All three valid continuously with addrs 1, 2, 3 and ptr=0.
  - Grants 0,1,2,0,1,2; wr_addr sequence 1,2,3,1,2,3.
  - No requester starves.
- x0 suppression: requester 2 sends addr 0, data 0xFFFFFFFF → req_ready[2]=1, next cycle wr_en=0, register 0 still reads 0.
- Collision:
  - Requester 0 writes addr 7 = 0x11 and requester 1 writes addr 7 = 0x22 in the same cycle, ptr=0.
  - Two consecutive writes occur, 0x11 then 0x22; register 7 ends at 0x22.
- Reset mid-sweep and mid-run:
  - Assert reset at sweep address 12 → wr_en=0 immediately; after release the sweep restarts at 0.
  - Assert reset while RUN traffic is flowing → pending writes are dropped and INIT is re-entered.
